// File: rtl/int_arith_pkg.sv
// int_arith_pkg: shared state type and sizing helper for the integer accumulator datapath
package int_arith_pkg;
  typedef enum logic {ACCUM, HOLD} accum_state_t;
  function automatic int cnt_width(input int beats);
    return beats > 1 ? $clog2(beats) : 1;
  endfunction
endpackage

// File: rtl/int_accumulator_lane.sv
// int_accumulator_lane: one full-precision signed running-sum register for a single element
module int_accumulator_lane #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 18
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 add,
  input  logic                 hold,
  input  logic [IN_WIDTH-1:0]  din,
  output logic [OUT_WIDTH-1:0] acc
);
  logic [OUT_WIDTH-1:0] ext;
  assign ext = OUT_WIDTH'($signed(din));
  always_ff @(posedge clk)
    if (rst) acc <= '0;
    else if (!hold) acc <= load ? ext : add ? acc + ext : acc;
endmodule

// File: rtl/int_entrywise_accumulator.sv
// int_entrywise_accumulator: sums NUM_BEATS signed vectors entrywise and emits one full-precision vector per group
module int_entrywise_accumulator
  import int_arith_pkg::*;
#(
  parameter  int IN_WIDTH  = 16,
  parameter  int DIM       = 8,
  parameter  int NUM_BEATS = 4,
  localparam int OUT_WIDTH = IN_WIDTH + $clog2(NUM_BEATS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DIM-1:0][IN_WIDTH-1:0]  data_in,
  input  logic                          valid_in,
  output logic                          ready_in,
  output logic [DIM-1:0][OUT_WIDTH-1:0] data_out,
  output logic                          valid_out,
  input  logic                          ready_out
);
  localparam int CW = cnt_width(NUM_BEATS);
  accum_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic in_xfer, last, load, add;
  assign ready_in  = state == ACCUM || ready_out;
  assign valid_out = state == HOLD;
  assign in_xfer   = valid_in && ready_in;
  assign last      = cnt == CW'(NUM_BEATS - 1);
  // cnt is always 0 in HOLD, so an input accepted there naturally becomes beat 0
  assign load      = in_xfer && cnt == '0;
  assign add       = in_xfer && cnt != '0;
  always_ff @(posedge clk)
    if (rst) begin
      state <= ACCUM;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  always_comb begin
    state_n = in_xfer ? (last ? HOLD : ACCUM) : (valid_out && ready_out ? ACCUM : state);
    cnt_n   = in_xfer ? (last ? '0 : cnt + 1'b1) : cnt;
  end
  for (genvar i = 0; i < DIM; i++) begin : g_lane
    int_accumulator_lane #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH)) u_lane (
      .clk (clk),
      .rst (rst),
      .load(load),
      .add (add),
      .hold(!in_xfer),
      .din (data_in[i]),
      .acc (data_out[i])
    );
  end
endmodule

// File: tb/tb_int_entrywise_accumulator.sv
// tb_int_entrywise_accumulator: randomized scenario bench against an arithmetic group-sum model
module tb_int_entrywise_accumulator;
  localparam int IW = 16;
  localparam int D  = 2;
  localparam int NB = 4;
  localparam int OW = IW + $clog2(NB);

  typedef int vec_t[D];

  logic clk = 1'b0;
  logic rst, vin, rin, vout, rout;
  logic [D-1:0][IW-1:0] din;
  logic [D-1:0][OW-1:0] dout;
  logic rst1, vin1, rin1, vout1, rout1;
  logic [D-1:0][IW-1:0] din1;
  logic [D-1:0][IW-1:0] dout1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  int_entrywise_accumulator #(.IN_WIDTH(IW), .DIM(D), .NUM_BEATS(NB)) dut (
    .clk(clk), .rst(rst), .data_in(din), .valid_in(vin), .ready_in(rin),
    .data_out(dout), .valid_out(vout), .ready_out(rout)
  );

  int_entrywise_accumulator #(.IN_WIDTH(IW), .DIM(D), .NUM_BEATS(1)) dut1 (
    .clk(clk), .rst(rst1), .data_in(din1), .valid_in(vin1), .ready_in(rin1),
    .data_out(dout1), .valid_out(vout1), .ready_out(rout1)
  );

  function automatic int got(input int i);
    return int'($signed(dout[i]));
  endfunction

  function automatic int got1(input int i);
    return int'($signed(dout1[i]));
  endfunction

  function automatic void model_sum(input vec_t g[NB], output vec_t s);
    for (int i = 0; i < D; i++) begin
      s[i] = 0;
      for (int b = 0; b < NB; b++) s[i] += g[b][i];
    end
  endfunction

  function automatic void rand_vec(output vec_t v);
    for (int i = 0; i < D; i++) v[i] = int'($signed(IW'($urandom)));
  endfunction

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    for (int i = 0; i < D; i++) din[i] = IW'(v[i]);
  endtask

  task automatic drive1(input vec_t v);
    for (int i = 0; i < D; i++) din1[i] = IW'(v[i]);
  endtask

  task automatic test_reset();
    rst = 1'b1; rst1 = 1'b1; vin = 1'b0; vin1 = 1'b0; rout = 1'b1; rout1 = 1'b1;
    din = '0; din1 = '0;
    go(); go();
    rst = 1'b0; rst1 = 1'b0;
    @(negedge clk);
    n_tests++; if (vout !== 1'b0) begin n_fail++; $display("FAIL reset_vout: got %b want 0", vout); end
    n_tests++; if (rin !== 1'b1) begin n_fail++; $display("FAIL reset_rin: got %b want 1", rin); end
    n_tests++; if (dout !== '0) begin n_fail++; $display("FAIL reset_dout: got %h want 0", dout); end
    n_tests++; if (vout1 !== 1'b0) begin n_fail++; $display("FAIL reset_vout1: got %b want 0", vout1); end
    n_tests++; if (rin1 !== 1'b1) begin n_fail++; $display("FAIL reset_rin1: got %b want 1", rin1); end
    go();
  endtask

  task automatic test_basic();
    vec_t g[NB];
    vec_t e;
    g[0] = '{1, -1}; g[1] = '{2, -2}; g[2] = '{3, -3}; g[3] = '{4, -4};
    model_sum(g, e);
    rout = 1'b1;
    for (int b = 0; b < NB; b++) begin
      drive(g[b]); vin = 1'b1;
      @(negedge clk);
      n_tests++; if (vout !== 1'b0) begin n_fail++; $display("FAIL basic_early_vout beat %0d: got %b want 0", b, vout); end
      go();
    end
    vin = 1'b0;
    @(negedge clk);
    n_tests++; if (vout !== 1'b1) begin n_fail++; $display("FAIL basic_vout: got %b want 1", vout); end
    for (int i = 0; i < D; i++) begin
      n_tests++; if (got(i) !== e[i]) begin n_fail++; $display("FAIL basic_sum[%0d]: got %0d want %0d", i, got(i), e[i]); end
    end
    go();
    @(negedge clk);
    n_tests++; if (vout !== 1'b0) begin n_fail++; $display("FAIL basic_one_cycle: got %b want 0", vout); end
    go();
  endtask

  task automatic test_extremes();
    vec_t g[NB];
    vec_t e;
    for (int b = 0; b < NB; b++) g[b] = '{-32768, 32767};
    model_sum(g, e);
    rout = 1'b1;
    for (int b = 0; b < NB; b++) begin
      drive(g[b]); vin = 1'b1;
      go();
    end
    vin = 1'b0;
    @(negedge clk);
    n_tests++; if (vout !== 1'b1) begin n_fail++; $display("FAIL extremes_vout: got %b want 1", vout); end
    for (int i = 0; i < D; i++) begin
      n_tests++; if (got(i) !== e[i]) begin n_fail++; $display("FAIL extremes_sum[%0d]: got %0d want %0d", i, got(i), e[i]); end
    end
    go();
  endtask

  task automatic test_backpressure();
    vec_t g[NB], h[NB];
    vec_t e, f;
    for (int b = 0; b < NB; b++) begin rand_vec(g[b]); rand_vec(h[b]); end
    model_sum(g, e);
    model_sum(h, f);
    rout = 1'b0;
    for (int b = 0; b < NB; b++) begin
      drive(g[b]); vin = 1'b1;
      go();
    end
    drive(h[0]); vin = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_tests++; if (rin !== 1'b0) begin n_fail++; $display("FAIL bp_rin cycle %0d: got %b want 0", c, rin); end
      n_tests++; if (vout !== 1'b1) begin n_fail++; $display("FAIL bp_vout cycle %0d: got %b want 1", c, vout); end
      for (int i = 0; i < D; i++) begin
        n_tests++; if (got(i) !== e[i]) begin n_fail++; $display("FAIL bp_hold[%0d] cycle %0d: got %0d want %0d", i, c, got(i), e[i]); end
      end
      go();
    end
    rout = 1'b1;
    @(negedge clk);
    n_tests++; if (rin !== 1'b1) begin n_fail++; $display("FAIL bp_release_rin: got %b want 1", rin); end
    go();
    for (int b = 1; b < NB; b++) begin
      drive(h[b]); vin = 1'b1;
      @(negedge clk);
      n_tests++; if (vout !== 1'b0) begin n_fail++; $display("FAIL bp_next_vout beat %0d: got %b want 0", b, vout); end
      go();
    end
    vin = 1'b0;
    @(negedge clk);
    n_tests++; if (vout !== 1'b1) begin n_fail++; $display("FAIL bp_next_valid: got %b want 1", vout); end
    for (int i = 0; i < D; i++) begin
      n_tests++; if (got(i) !== f[i]) begin n_fail++; $display("FAIL bp_next_sum[%0d]: got %0d want %0d", i, got(i), f[i]); end
    end
    go();
  endtask

  task automatic test_back_to_back();
    vec_t g[3*NB];
    vec_t grp[NB];
    vec_t e[3];
    for (int k = 0; k < 3*NB; k++) rand_vec(g[k]);
    for (int n = 0; n < 3; n++) begin
      for (int b = 0; b < NB; b++) grp[b] = g[n*NB + b];
      model_sum(grp, e[n]);
    end
    rout = 1'b1;
    for (int k = 0; k < 3*NB; k++) begin
      drive(g[k]); vin = 1'b1;
      @(negedge clk);
      n_tests++; if (rin !== 1'b1) begin n_fail++; $display("FAIL b2b_rin cycle %0d: got %b want 1", k, rin); end
      if (k % NB == 0 && k > 0) begin
        n_tests++; if (vout !== 1'b1) begin n_fail++; $display("FAIL b2b_vout cycle %0d: got %b want 1", k, vout); end
        for (int i = 0; i < D; i++) begin
          n_tests++; if (got(i) !== e[k/NB-1][i]) begin n_fail++; $display("FAIL b2b_sum[%0d] group %0d: got %0d want %0d", i, k/NB-1, got(i), e[k/NB-1][i]); end
        end
      end else begin
        n_tests++; if (vout !== 1'b0) begin n_fail++; $display("FAIL b2b_vout cycle %0d: got %b want 0", k, vout); end
      end
      go();
    end
    vin = 1'b0;
    @(negedge clk);
    n_tests++; if (vout !== 1'b1) begin n_fail++; $display("FAIL b2b_last_vout: got %b want 1", vout); end
    for (int i = 0; i < D; i++) begin
      n_tests++; if (got(i) !== e[2][i]) begin n_fail++; $display("FAIL b2b_sum[%0d] group 2: got %0d want %0d", i, got(i), e[2][i]); end
    end
    go();
  endtask

  task automatic test_gaps();
    vec_t g[NB];
    vec_t e, junk;
    for (int b = 0; b < NB; b++) rand_vec(g[b]);
    model_sum(g, e);
    rout = 1'b1;
    for (int b = 0; b < NB; b++) begin
      drive(g[b]); vin = 1'b1;
      @(negedge clk);
      n_tests++; if (vout !== 1'b0) begin n_fail++; $display("FAIL gaps_vout beat %0d: got %b want 0", b, vout); end
      go();
      vin = 1'b0;
      rand_vec(junk); drive(junk);
      if (b < NB - 1) begin
        repeat ($urandom_range(1, 3)) begin
          @(negedge clk);
          n_tests++; if (vout !== 1'b0) begin n_fail++; $display("FAIL gaps_idle_vout beat %0d: got %b want 0", b, vout); end
          go();
        end
      end
    end
    @(negedge clk);
    n_tests++; if (vout !== 1'b1) begin n_fail++; $display("FAIL gaps_valid: got %b want 1", vout); end
    for (int i = 0; i < D; i++) begin
      n_tests++; if (got(i) !== e[i]) begin n_fail++; $display("FAIL gaps_sum[%0d]: got %0d want %0d", i, got(i), e[i]); end
    end
    go();
  endtask

  task automatic test_reset_mid();
    vec_t v;
    vec_t g[NB];
    vec_t e;
    rout = 1'b1;
    for (int b = 0; b < 2; b++) begin
      rand_vec(v); drive(v); vin = 1'b1;
      go();
    end
    rand_vec(v); drive(v); vin = 1'b1; rst = 1'b1;
    go();
    rst = 1'b0; vin = 1'b0;
    @(negedge clk);
    n_tests++; if (vout !== 1'b0) begin n_fail++; $display("FAIL rstmid_vout: got %b want 0", vout); end
    n_tests++; if (dout !== '0) begin n_fail++; $display("FAIL rstmid_cleared: got %h want 0", dout); end
    go();
    for (int b = 0; b < NB; b++) g[b] = '{5, 5};
    model_sum(g, e);
    for (int b = 0; b < NB; b++) begin
      drive(g[b]); vin = 1'b1;
      go();
    end
    vin = 1'b0;
    @(negedge clk);
    n_tests++; if (vout !== 1'b1) begin n_fail++; $display("FAIL rstmid_valid: got %b want 1", vout); end
    for (int i = 0; i < D; i++) begin
      n_tests++; if (got(i) !== e[i]) begin n_fail++; $display("FAIL rstmid_sum[%0d]: got %0d want %0d", i, got(i), e[i]); end
    end
    go();
  endtask

  task automatic test_single_beat();
    vec_t v[6];
    for (int k = 0; k < 6; k++) rand_vec(v[k]);
    rout1 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      drive1(v[k]); vin1 = 1'b1;
      @(negedge clk);
      n_tests++; if (rin1 !== 1'b1) begin n_fail++; $display("FAIL nb1_rin cycle %0d: got %b want 1", k, rin1); end
      if (k > 0) begin
        n_tests++; if (vout1 !== 1'b1) begin n_fail++; $display("FAIL nb1_vout cycle %0d: got %b want 1", k, vout1); end
        for (int i = 0; i < D; i++) begin
          n_tests++; if (got1(i) !== v[k-1][i]) begin n_fail++; $display("FAIL nb1_echo[%0d] cycle %0d: got %0d want %0d", i, k, got1(i), v[k-1][i]); end
        end
      end
      go();
    end
    vin1 = 1'b0;
    @(negedge clk);
    for (int i = 0; i < D; i++) begin
      n_tests++; if (got1(i) !== v[5][i]) begin n_fail++; $display("FAIL nb1_last[%0d]: got %0d want %0d", i, got1(i), v[5][i]); end
    end
    go();
    @(negedge clk);
    n_tests++; if (vout1 !== 1'b0) begin n_fail++; $display("FAIL nb1_drain: got %b want 0", vout1); end
    go();
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_extremes();
    test_backpressure();
    test_back_to_back();
    test_gaps();
    test_reset_mid();
    test_single_beat();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
